// File: rtl/button_multi_counter.sv
// rtl/button_multi_counter.sv - multi-channel debounced push-button up/down counter with auto-repeat
module button_multi_counter #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int STEP         = 1,
    parameter int DEBOUNCE     = 16,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int SATURATE     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic [CHANNELS-1:0]       b_in,
    input  logic [CHANNELS-1:0]       dir,
    input  logic                      clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       evt,
    output logic [CHANNELS-1:0]       ovf
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(HOLD_TICKS + 2);
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]       sync;
        logic             s;
        logic             db;
        logic [DW-1:0]    db_cnt;
        logic [HW-1:0]    hold_cnt;
        logic [RW-1:0]    rep_cnt;
        logic [WIDTH-1:0] cnt;
        logic             evt_r;
        logic             ovf_r;

        logic             accept;
        logic             press;
        logic             rep_fire;
        logic             ev;
        logic [WIDTH:0]   up_sum;
        logic [WIDTH:0]   dn_diff;
        logic             ofl;
        logic [WIDTH-1:0] nxt;

        assign s = sync[1];

        always_comb begin
            accept   = ce && (s != db) && (db_cnt == DW'(DEBOUNCE - 1));
            press    = accept && s;
            rep_fire = 1'b0;
            // A repeat never fires on the tick that accepts the release.
            if (HOLD_TICKS > 0 && ce && db && !accept) begin
                if (hold_cnt < HW'(HOLD_TICKS))
                    rep_fire = (hold_cnt == HW'(HOLD_TICKS - 1));
                else
                    rep_fire = (rep_cnt == RW'(REPEAT_TICKS - 1));
            end
            ev      = press || rep_fire;
            up_sum  = {1'b0, cnt} + {1'b0, STEP_W};
            dn_diff = {1'b0, cnt} - {1'b0, STEP_W};
            ofl     = dir[g] ? dn_diff[WIDTH] : up_sum[WIDTH];
            if (dir[g])
                nxt = (SATURATE != 0 && ofl) ? '0 : dn_diff[WIDTH-1:0];
            else
                nxt = (SATURATE != 0 && ofl) ? '1 : up_sum[WIDTH-1:0];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync     <= '0;
                db       <= 1'b0;
                db_cnt   <= '0;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                cnt      <= '0;
                evt_r    <= 1'b0;
                ovf_r    <= 1'b0;
            end else begin
                sync <= {sync[0], b_in[g]};

                if (ce) begin
                    if (s == db) begin
                        db_cnt <= '0;
                    end else if (accept) begin
                        db     <= s;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end

                // Hold counter restarts from 0 on every press, so press and repeat cannot coincide.
                if (!db || HOLD_TICKS == 0) begin
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end else if (ce && !accept) begin
                    if (hold_cnt < HW'(HOLD_TICKS)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                        rep_cnt  <= '0;
                    end else begin
                        rep_cnt <= rep_fire ? '0 : rep_cnt + RW'(1);
                    end
                end

                evt_r <= ev;
                if (clr) begin
                    cnt   <= '0;
                    ovf_r <= 1'b0;
                end else if (ev) begin
                    cnt   <= nxt;
                    ovf_r <= ofl;
                end else begin
                    ovf_r <= 1'b0;
                end
            end
        end

        assign count[g*WIDTH +: WIDTH] = cnt;
        assign evt[g]                  = evt_r;
        assign ovf[g]                  = ovf_r;
    end
endmodule

// File: tb/tb_button_multi_counter.sv
// tb/tb_button_multi_counter.sv - table-driven bench for button_multi_counter, wrap and saturate builds
module tb_button_multi_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  b_in = '0;
    logic [1:0]  dir  = '0;
    logic [15:0] count_w, count_s;
    logic [1:0]  evt_w, evt_s, ovf_w, ovf_s;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    button_multi_counter #(
        .CHANNELS(2), .WIDTH(8), .STEP(1), .DEBOUNCE(4),
        .HOLD_TICKS(10), .REPEAT_TICKS(3), .SATURATE(0)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .b_in(b_in), .dir(dir), .clr(clr),
        .count(count_w), .evt(evt_w), .ovf(ovf_w)
    );

    button_multi_counter #(
        .CHANNELS(2), .WIDTH(8), .STEP(1), .DEBOUNCE(4),
        .HOLD_TICKS(10), .REPEAT_TICKS(3), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rst(rst), .ce(ce), .b_in(b_in), .dir(dir), .clr(clr),
        .count(count_s), .evt(evt_s), .ovf(ovf_s)
    );

    typedef struct {
        logic [1:0] b;
        logic [1:0] d;
        logic       c;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] ev;
        logic [1:0] ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input int n, input logic [1:0] b, input logic [1:0] d, input logic c,
                       input logic [7:0] c0, input logic [7:0] c1,
                       input logic [1:0] ev, input logic [1:0] ov);
        vec_t v;
        v.b = b; v.d = d; v.c = c; v.c0 = c0; v.c1 = c1; v.ev = ev; v.ov = ov;
        repeat (n) vecs.push_back(v);
    endtask

    // One ce tick: inputs settle through the synchroniser for 3 clk, ce on the 4th.
    task automatic do_tick(input logic [1:0] b, input logic [1:0] d, input logic c);
        @(negedge clk);
        b_in = b; dir = d; ce = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        ce = 1'b0; clr = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int k;
        int hit_tick;

        // clean press ch0, held 6 ticks
        add(3, 2'b01, 2'b00, 0, 0, 0, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 1, 0, 2'b01, 2'b00);
        add(2, 2'b01, 2'b00, 0, 1, 0, 2'b00, 2'b00);
        add(4, 2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b00);
        // bounce then settle
        add(1, 2'b01, 2'b00, 0, 1, 0, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 1, 0, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b00);
        add(3, 2'b01, 2'b00, 0, 1, 0, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 2, 0, 2'b01, 2'b00);
        add(4, 2'b00, 2'b00, 0, 2, 0, 2'b00, 2'b00);
        // ch1 press
        add(3, 2'b10, 2'b00, 0, 2, 0, 2'b00, 2'b00);
        add(1, 2'b10, 2'b00, 0, 2, 1, 2'b10, 2'b00);
        add(4, 2'b00, 2'b00, 0, 2, 1, 2'b00, 2'b00);
        // clr coincident with ch1 press, then a repeat on the third release tick
        add(3, 2'b10, 2'b00, 0, 2, 1, 2'b00, 2'b00);
        add(1, 2'b10, 2'b00, 1, 0, 0, 2'b10, 2'b00);
        add(7, 2'b10, 2'b00, 0, 0, 0, 2'b00, 2'b00);
        add(2, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 0, 0, 1, 2'b10, 2'b00);
        add(1, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00);
        // hold ch0: press, repeats at held ticks 10, 13, 16, 19
        add(3, 2'b01, 2'b00, 0, 0, 1, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 1, 1, 2'b01, 2'b00);
        add(9, 2'b01, 2'b00, 0, 1, 1, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 2, 1, 2'b01, 2'b00);
        add(2, 2'b01, 2'b00, 0, 2, 1, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 3, 1, 2'b01, 2'b00);
        add(2, 2'b01, 2'b00, 0, 3, 1, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 4, 1, 2'b01, 2'b00);
        add(2, 2'b00, 2'b00, 0, 4, 1, 2'b00, 2'b00);
        add(1, 2'b00, 2'b00, 0, 5, 1, 2'b01, 2'b00);
        add(1, 2'b00, 2'b00, 0, 5, 1, 2'b00, 2'b00);
        // ch1 down 1->0, down 0->255 (borrow), up 255->0 (carry)
        add(3, 2'b10, 2'b10, 0, 5, 1, 2'b00, 2'b00);
        add(1, 2'b10, 2'b10, 0, 5, 0, 2'b10, 2'b00);
        add(4, 2'b00, 2'b10, 0, 5, 0, 2'b00, 2'b00);
        add(3, 2'b10, 2'b10, 0, 5, 0, 2'b00, 2'b00);
        add(1, 2'b10, 2'b10, 0, 5, 255, 2'b10, 2'b10);
        add(4, 2'b00, 2'b10, 0, 5, 255, 2'b00, 2'b00);
        add(3, 2'b10, 2'b00, 0, 5, 255, 2'b00, 2'b00);
        add(1, 2'b10, 2'b00, 0, 5, 0, 2'b10, 2'b10);
        add(4, 2'b00, 2'b00, 0, 5, 0, 2'b00, 2'b00);
        // simultaneous presses on both channels
        add(3, 2'b11, 2'b00, 0, 5, 0, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 0, 6, 1, 2'b11, 2'b00);
        add(4, 2'b00, 2'b00, 0, 6, 1, 2'b00, 2'b00);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset count", count_w, 0);
        chk("reset evt", evt_w, 0);
        chk("reset ovf", ovf_w, 0);
        chk("reset count sat", count_s, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            do_tick(vecs[i].b, vecs[i].d, vecs[i].c);
            chk($sformatf("row%0d count0", i), count_w[7:0], vecs[i].c0);
            chk($sformatf("row%0d count1", i), count_w[15:8], vecs[i].c1);
            chk($sformatf("row%0d evt", i), evt_w, vecs[i].ev);
            chk($sformatf("row%0d ovf", i), ovf_w, vecs[i].ov);
        end

        // async reset mid-hold with count0=7, button kept held
        repeat (3) do_tick(2'b01, 2'b00, 1'b0);
        do_tick(2'b01, 2'b00, 1'b0);
        chk("pre-reset count0", count_w[7:0], 7);
        repeat (3) do_tick(2'b01, 2'b00, 1'b0);
        @(negedge clk);
        ce = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async reset count", count_w, 0);
        chk("async reset count sat", count_s, 0);
        chk("async reset evt", evt_w, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            do_tick(2'b01, 2'b00, 1'b0);
            chk($sformatf("post-reset t%0d evt", t), evt_w, 0);
        end
        do_tick(2'b01, 2'b00, 1'b0);
        chk("post-reset press count0", count_w[7:0], 1);
        chk("post-reset press evt", evt_w, 2'b01);
        repeat (4) do_tick(2'b00, 2'b00, 1'b0);

        // saturate vs wrap on ch1 from 0
        pulse_reset();
        repeat (3) do_tick(2'b10, 2'b10, 1'b0);
        do_tick(2'b10, 2'b10, 1'b0);
        chk("down0 wrap count1", count_w[15:8], 255);
        chk("down0 wrap ovf", ovf_w, 2'b10);
        chk("down0 sat count1", count_s[15:8], 0);
        chk("down0 sat ovf", ovf_s, 2'b10);
        chk("down0 sat evt", evt_s, 2'b10);
        repeat (4) do_tick(2'b00, 2'b10, 1'b0);
        repeat (3) do_tick(2'b10, 2'b00, 1'b0);
        do_tick(2'b10, 2'b00, 1'b0);
        chk("up255 wrap count1", count_w[15:8], 0);
        chk("up255 wrap ovf", ovf_w, 2'b10);
        chk("up1 sat count1", count_s[15:8], 1);
        chk("up1 sat ovf", ovf_s, 2'b00);
        repeat (4) do_tick(2'b00, 2'b00, 1'b0);

        // hold ch0 up through 256 events: press at tick 4, last repeat at held tick 772
        k = 0;
        hit_tick = 0;
        for (int t = 1; t <= 1000 && k < 256; t++) begin
            do_tick(2'b01, 2'b00, 1'b0);
            if (evt_w[0]) begin
                k++;
                if (k == 255) begin
                    chk("ev255 wrap count0", count_w[7:0], 255);
                    chk("ev255 sat count0", count_s[7:0], 255);
                    chk("ev255 sat ovf", ovf_s, 2'b00);
                end
                if (k == 256) begin
                    hit_tick = t;
                    chk("ev256 wrap count0", count_w[7:0], 0);
                    chk("ev256 wrap ovf", ovf_w, 2'b01);
                    chk("ev256 sat count0", count_s[7:0], 255);
                    chk("ev256 sat ovf", ovf_s, 2'b01);
                    chk("ev256 sat evt", evt_s, 2'b01);
                end
            end
        end
        chk("hold event total", k, 256);
        chk("hold 256th tick", hit_tick, 776);
        repeat (4) do_tick(2'b00, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/button_multi_counter.md
# button_multi_counter

Parametrised multi-channel push-button counter: each channel synchronises, debounces and edge-detects a raw button, then adds or subtracts a step on every press, with optional auto-repeat while held and selectable wrap or saturate arithmetic. It sits behind the board buttons and is advanced by a slow clock-enable strobe from the frequency divider. The design runs on the main clock; no derived clock is used. Counts drive LEDs or displays directly.

## Interface
- CHANNELS, 4: number of independent button/counter channels
- WIDTH, 8: bits per counter
- STEP, 1: increment/decrement per event, WIDTH bits, nonzero
- DEBOUNCE, 16: consecutive `ce` ticks of stable input needed to accept a level change, ≥1
- HOLD_TICKS, 500: `ce` ticks held before the first auto-repeat; 0 disables auto-repeat
- REPEAT_TICKS, 100: `ce` ticks between later auto-repeats, ≥1
- SATURATE, 0: 0 = modulo 2^WIDTH wrap, 1 = clamp at 0 / 2^WIDTH−1
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- ce  input  1  tick strobe, one `clk` wide (e.g. 1 kHz); all debounce and hold timing counts these
- b_in  input  CHANNELS  raw button levels, asynchronous, 1 = pressed
- dir  input  CHANNELS  per-channel direction, 0 = up, 1 = down, sampled at the event edge
- clr  input  1  synchronous clear of all counts
- count  output  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH], registered
- event  output  CHANNELS  one-`clk` pulse per count event (press or repeat)
- ovf  output  CHANNELS  one-`clk` pulse when an event wraps or is clamped

## Operation
- Reset (rst=0) clears all state asynchronously: count=0, event=0, ovf=0, synchronisers=0, debounced level db=0, debounce and hold counters=0.
- Synchroniser: two flops per channel on every `clk`, independent of `ce`. Output is s.
- Debounce, evaluated only when ce=1:
  - If s==db, clear the debounce counter.
  - Otherwise increment it. When the counter reaches DEBOUNCE−1, set db<=s and clear the counter.
  - DEBOUNCE=1 accepts a change on the first `ce` tick that sees it.
- Press event: the edge where db goes 0→1.
- Hold and repeat, only when HOLD_TICKS>0:
  - While db=1, the hold counter counts `ce` ticks and saturates. It is cleared when db=0.
  - The first repeat event fires on the tick where the held-tick count reaches HOLD_TICKS.
  - Later repeat events fire every REPEAT_TICKS ticks while db stays 1.
  - Release stops repeats immediately.
  - Press and repeat never coincide, because the hold counter starts at 0 on press.
- Count update on an event:
  - dir=0: count+STEP. dir=1: count−STEP.
  - SATURATE=0: result mod 2^WIDTH. ovf pulses if a carry or borrow occurred.
  - SATURATE=1: result clamps to 2^WIDTH−1 or 0. ovf pulses when clamping occurred or the count was already at the limit.
- clr=1: every count<=0 on that edge. clr beats a simultaneous event: count=0, but event still pulses and ovf stays 0. clr does not disturb debounce or hold state.
- Channels are fully independent. Simultaneous events on several channels are all applied on the same edge.
- Release (db 1→0) produces no event.

## Timing
- b_in change to s: 2 `clk` edges.
- s stable to db update: the DEBOUNCE-th `ce` tick after s changes, counting ticks where s≠db.
- A glitch shorter than DEBOUNCE ticks is discarded: the counter clears on any tick where s==db.
- db, count, event and ovf all update on the same `clk` edge: the edge of the `ce` tick that accepts the change or fires the repeat.
- event and ovf are high for exactly the one `clk` cycle after that edge.
- Zero extra latency from event to count.
- Reset asserted mid-hold or mid-debounce aborts immediately. After release, no event occurs until a fresh 0→1 is debounced, even if the button is still held: db restarts at 0, so a held button produces one press DEBOUNCE ticks after reset.

## Test plan
Bench configuration: CHANNELS=2, WIDTH=8, STEP=1, DEBOUNCE=4, HOLD_TICKS=10, REPEAT_TICKS=3, ce every 4 clk.
- Clean press ch0, held 6 ticks, then released: count0 goes 0→1 on the 4th tick after sync; one event pulse; count1 stays 0.
- Bounce: ch0 toggles every tick for 3 ticks, then settles high: no event during bounce; exactly one increment, 4 ticks after settling.
- Hold ch0 for 20 ticks: press at tick 4, repeats at held ticks 10, 13, 16, 19; count0=5; no event on release.
- Wrap: preload 255 by presses, then press with dir=0: count=0 and ovf pulses. Rerun with SATURATE=1: count stays 255, ovf pulses. Down from 0 with dir=1 gives 255 (wrap) or 0 (sat).
- clr on the same edge as a ch1 press: count1=0, event1=1, ovf1=0. Debounce continues and a later repeat gives count1=1.
- Async reset asserted mid-hold with count0=7: count0=0 immediately. Button still held: one press 4 ticks after release of reset, count0=1.
